// File: rtl/sixteenbit_downcounter_pkg.sv
// Shared definitions for the 16-bit countdown timer.
//   state_e        : controller states (IDLE, RUN, DONE)
//   SEG_0..SEG_F   : active-low 7-segment glyphs, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK      : all segments off
package sixteenbit_downcounter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sixteenbit_downcounter_seg7.sv
// Hex nibble to 7-segment decoder (combinational).
//   nibble_i : 4-bit value to display
//   seg_o    : active-low segments {g,f,e,d,c,b,a}
module seg7_nibble_decoder
   import sixteenbit_downcounter_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (nibble_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = SEG_A;
         4'hB: seg_o = SEG_B;
         4'hC: seg_o = SEG_C;
         4'hD: seg_o = SEG_D;
         4'hE: seg_o = SEG_E;
         4'hF: seg_o = SEG_F;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sixteenbit_downcounter.sv
// Loadable 16-bit countdown timer with prescaler and 4-digit hex display.
//   Clk        : system clock, rising edge
//   ClrN       : asynchronous active-low reset
//   Load       : synchronous load strobe (priority over En), Q <= D
//   En         : count enable; low freezes Q and the prescaler
//   D          : load value
//   Q          : current count
//   Busy       : high while counting (RUN)
//   Done       : registered one-cycle pulse on reaching terminal count
//   HEX0..HEX3 : active-low segments for Q[3:0] .. Q[15:12]
// Build option: define AUTO_RELOAD_EN to reload the last loaded value on the
// terminal tick instead of stopping at zero.
module sixteenbit_downcounter
   import sixteenbit_downcounter_pkg::*;
#(
   parameter int TICK_DIV = 1,
   parameter int PRE_W    = 26
) (
   input  logic        Clk,
   input  logic        ClrN,
   input  logic        Load,
   input  logic        En,
   input  logic [15:0] D,
   output logic [15:0] Q,
   output logic        Busy,
   output logic        Done,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   state_e            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic              done_q, done_d;

`ifdef AUTO_RELOAD_EN
   logic [15:0]       reload_q;

   always_ff @(posedge Clk or negedge ClrN) begin
      if (!ClrN) begin
         reload_q <= '0;
      end else if (Load) begin
         reload_q <= D;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pre_d   = pre_q;
      done_d  = 1'b0;
      if (Load) begin
         cnt_d = D;
         pre_d = '0;
         if (D != 16'd0) begin
            state_d = ST_RUN;
         end else begin
            // Loading zero is an immediate terminal: report it straight away.
            state_d = ST_DONE;
            done_d  = 1'b1;
         end
      end else if ((state_q == ST_RUN) && En) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (cnt_q == 16'd1) begin
               done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
               cnt_d  = reload_q;
`else
               cnt_d   = '0;
               state_d = ST_DONE;
`endif
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end
   end

   always_ff @(posedge Clk or negedge ClrN) begin
      if (!ClrN) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pre_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         done_q  <= done_d;
      end
   end

   assign Q    = cnt_q;
   assign Busy = (state_q == ST_RUN);
   assign Done = done_q;

   seg7_nibble_decoder u_hex0 (.nibble_i(cnt_q[3:0]),   .seg_o(HEX0));
   seg7_nibble_decoder u_hex1 (.nibble_i(cnt_q[7:4]),   .seg_o(HEX1));
   seg7_nibble_decoder u_hex2 (.nibble_i(cnt_q[11:8]),  .seg_o(HEX2));
   seg7_nibble_decoder u_hex3 (.nibble_i(cnt_q[15:12]), .seg_o(HEX3));

endmodule
